// File: rtl/perceptron_pkg.sv
// Shared types and constants for the perceptron layer scheduler and its weight bank.
package perceptron_pkg;

  // Default fixed-point format: sign, integer and fraction bits.
  localparam int unsigned DEF_SIGN = 1;
  localparam int unsigned DEF_Q_M  = 15;
  localparam int unsigned DEF_Q_N  = 16;
  localparam int unsigned W        = DEF_SIGN + DEF_Q_M + DEF_Q_N;

  typedef logic [W-1:0] fixed_t;

  typedef enum logic [1:0] {IDLE, EVAL, DONE} sched_state_t;

  // Encodings of the wr_sel field; 2'd3 is acknowledged but ignored.
  localparam logic [1:0] SEL_W1 = 2'd0;
  localparam logic [1:0] SEL_W2 = 2'd1;
  localparam logic [1:0] SEL_WB = 2'd2;

  // Width of a neuron index, never less than one bit.
  function automatic int unsigned addr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/perceptron_layer_scheduler_weight_bank.sv
// Per-neuron weight register file (w1, w2, wb) with synchronous write and
// combinational read. Out-of-range addresses and wr_sel==3 are dropped silently.
module weight_bank
  import perceptron_pkg::*;
#(
  parameter int unsigned NUM_NEURONS = 4,
  parameter int unsigned DW          = W,
  localparam int unsigned AW         = addr_width(NUM_NEURONS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [1:0]    wr_sel,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_w1,
  output logic [DW-1:0] rd_w2,
  output logic [DW-1:0] rd_wb
);

  logic [DW-1:0] w1_q [NUM_NEURONS];
  logic [DW-1:0] w2_q [NUM_NEURONS];
  logic [DW-1:0] wb_q [NUM_NEURONS];
  logic          addr_ok;

  assign addr_ok = int'(wr_addr) < int'(NUM_NEURONS);

  // Clear all weights on reset; otherwise apply one accepted write per cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_NEURONS); i++) begin
        w1_q[i] <= '0;
        w2_q[i] <= '0;
        wb_q[i] <= '0;
      end
    end else if (wr_en && addr_ok) begin
      unique case (wr_sel)
        SEL_W1:  w1_q[wr_addr] <= wr_data;
        SEL_W2:  w2_q[wr_addr] <= wr_data;
        SEL_WB:  wb_q[wr_addr] <= wr_data;
        default: ;
      endcase
    end
  end

  assign rd_w1 = w1_q[rd_addr];
  assign rd_w2 = w2_q[rd_addr];
  assign rd_wb = wb_q[rd_addr];

endmodule

// File: rtl/perceptron_layer_scheduler.sv
// Time-multiplexes one external combinational neuron over NUM_NEURONS weight sets,
// producing one activation vector per accepted input pair.
// Optional macro PERCEPTRON_SCHED_PIPE_EN registers n_out before capture, adding a
// drain cycle to EVAL (latency NUM_NEURONS+1 instead of NUM_NEURONS).
module perceptron_layer_scheduler
  import perceptron_pkg::*;
#(
  parameter int unsigned NUM_NEURONS = 4,
  parameter int unsigned SIGN        = DEF_SIGN,
  parameter int unsigned Q_M         = DEF_Q_M,
  parameter int unsigned Q_N         = DEF_Q_N,
  localparam int unsigned WORD_W     = SIGN + Q_M + Q_N,
  localparam int unsigned AW         = addr_width(NUM_NEURONS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [AW-1:0]                 wr_addr,
  input  logic [1:0]                    wr_sel,
  input  logic [WORD_W-1:0]             wr_data,
  output logic                          wr_ready,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WORD_W-1:0]             x1_in,
  input  logic [WORD_W-1:0]             x2_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_NEURONS*WORD_W-1:0] out_vec,
  output logic [WORD_W-1:0]             n_x1,
  output logic [WORD_W-1:0]             n_x2,
  output logic [WORD_W-1:0]             n_w1,
  output logic [WORD_W-1:0]             n_w2,
  output logic [WORD_W-1:0]             n_wb,
  input  logic [WORD_W-1:0]             n_out
);

  // idx may reach NUM_NEURONS during the pipelined drain cycle.
  localparam int unsigned IW            = $clog2(NUM_NEURONS + 1);
  localparam logic [IW-1:0] LAST_IDX    = IW'(NUM_NEURONS - 1);

  sched_state_t        state_q;
  logic [IW-1:0]       idx_q;
  logic [WORD_W-1:0]   x1_q;
  logic [WORD_W-1:0]   x2_q;
  logic [WORD_W-1:0]   out_vec_q [NUM_NEURONS];
  logic                out_valid_q;
  logic [AW-1:0]       rd_addr;
  logic [AW-1:0]       cur_addr;

`ifdef PERCEPTRON_SCHED_PIPE_EN
  localparam logic [IW-1:0] DRAIN_IDX = IW'(NUM_NEURONS);
  logic [WORD_W-1:0]   n_out_q;
  logic [IW-1:0]       prev_idx;
  logic [AW-1:0]       prev_addr;

  assign prev_idx  = idx_q - IW'(1);
  assign prev_addr = prev_idx[AW-1:0];
`endif

  assign cur_addr = idx_q[AW-1:0];
  // Bank index 0 whenever no neuron is being evaluated, keeping n_* stable.
  assign rd_addr  = ((state_q == EVAL) && (idx_q <= LAST_IDX)) ? cur_addr : '0;

  assign in_ready  = (state_q == IDLE);
  assign wr_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign n_x1      = x1_q;
  assign n_x2      = x2_q;

  weight_bank #(
    .NUM_NEURONS (NUM_NEURONS),
    .DW          (WORD_W)
  ) u_weight_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en && wr_ready),
    .wr_addr (wr_addr),
    .wr_sel  (wr_sel),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_w1   (n_w1),
    .rd_w2   (n_w2),
    .rd_wb   (n_wb)
  );

  // Scheduler FSM: accept input, sweep neuron indices, hold the vector until taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      x1_q        <= '0;
      x2_q        <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < int'(NUM_NEURONS); i++) begin
        out_vec_q[i] <= '0;
      end
`ifdef PERCEPTRON_SCHED_PIPE_EN
      n_out_q     <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            x1_q    <= x1_in;
            x2_q    <= x2_in;
            idx_q   <= '0;
            state_q <= EVAL;
          end
        end
        EVAL: begin
`ifdef PERCEPTRON_SCHED_PIPE_EN
          n_out_q <= n_out;
          if (idx_q != '0) begin
            out_vec_q[prev_addr] <= n_out_q;
          end
          if (idx_q == DRAIN_IDX) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
`else
          out_vec_q[cur_addr] <= n_out;
          if (idx_q == LAST_IDX) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
`endif
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            idx_q       <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Flatten the captured activations; neuron i occupies bits [i*WORD_W +: WORD_W].
  always_comb begin
    out_vec = '0;
    for (int i = 0; i < int'(NUM_NEURONS); i++) begin
      out_vec[i*WORD_W +: WORD_W] = out_vec_q[i];
    end
  end

endmodule

// File: tb/tb_perceptron_layer_scheduler.sv
// Self-checking bench for perceptron_layer_scheduler with a behavioural neuron and
// a per-vector reference model built from the bank contents at acceptance time.
module tb_perceptron_layer_scheduler;
  import perceptron_pkg::*;

  localparam int N   = 4;
  localparam int AW  = 2;
  localparam int VW  = N * W;
`ifdef PERCEPTRON_SCHED_PIPE_EN
  localparam int LAT = N + 1;
`else
  localparam int LAT = N;
`endif
  localparam fixed_t ONE  = 32'h0001_0000;
  localparam fixed_t HALF = 32'h0000_8000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [1:0]    wr_sel;
  fixed_t        wr_data;
  logic          wr_ready;
  logic          in_valid;
  logic          in_ready;
  fixed_t        x1_in;
  fixed_t        x2_in;
  logic          out_valid;
  logic          out_ready;
  logic [VW-1:0] out_vec;
  fixed_t        n_x1, n_x2, n_w1, n_w2, n_wb, n_out;

  bit            use_step;
  int            n_tests = 0;
  int            n_fail  = 0;
  fixed_t        mw1 [N];
  fixed_t        mw2 [N];
  fixed_t        mwb [N];
  logic [VW-1:0] exp_q [$];

  always #5 clk = ~clk;

  perceptron_layer_scheduler #(
    .NUM_NEURONS (N)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_sel    (wr_sel),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x1_in     (x1_in),
    .x2_in     (x2_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vec   (out_vec),
    .n_x1      (n_x1),
    .n_x2      (n_x2),
    .n_w1      (n_w1),
    .n_w2      (n_w2),
    .n_wb      (n_wb),
    .n_out     (n_out)
  );

  // Q16.16 neuron: x1*w1 + x2*w2 + wb, optionally with step activation.
  function automatic fixed_t neuron_fn(input fixed_t x1, input fixed_t x2, input fixed_t w1,
                                       input fixed_t w2, input fixed_t wb, input bit step);
    longint p1, p2, s;
    p1 = longint'($signed(x1)) * longint'($signed(w1));
    p2 = longint'($signed(x2)) * longint'($signed(w2));
    s  = (p1 >>> DEF_Q_N) + (p2 >>> DEF_Q_N) + longint'($signed(wb));
    if (step) return (s >= 0) ? ONE : '0;
    return s[W-1:0];
  endfunction

  assign n_out = neuron_fn(n_x1, n_x2, n_w1, n_w2, n_wb, use_step);

  function automatic logic [VW-1:0] model_vec(input fixed_t a, input fixed_t b);
    logic [VW-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*W +: W] = neuron_fn(a, b, mw1[i], mw2[i], mwb[i], use_step);
    return v;
  endfunction

  task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: a vector transfers at the next edge when valid and ready are both high.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_vec", VW'(out_valid), VW'(0));
      else check("vec", out_vec, exp_q.pop_front());
    end
  end

  task automatic write_w(input int addr, input int sel, input fixed_t data, output int waited);
    wr_en   = 1'b1;
    wr_addr = addr[AW-1:0];
    wr_sel  = sel[1:0];
    wr_data = data;
    waited  = 0;
    while (wr_ready !== 1'b1 && waited < 50) begin
      tick;
      waited++;
    end
    if (waited >= 50) check("wr_timeout", VW'(wr_ready), VW'(1));
    tick;
    wr_en = 1'b0;
    if (addr < N) begin
      case (sel)
        0: mw1[addr] = data;
        1: mw2[addr] = data;
        2: mwb[addr] = data;
        default: ;
      endcase
    end
  endtask

  task automatic send_input(input fixed_t a, input fixed_t b, output int waited);
    in_valid = 1'b1;
    x1_in    = a;
    x2_in    = b;
    waited   = 0;
    while (in_ready !== 1'b1 && waited < 50) begin
      tick;
      waited++;
    end
    if (waited >= 50) check("in_timeout", VW'(in_ready), VW'(1));
    exp_q.push_back(model_vec(a, b));
    tick;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 50) begin
      tick;
      lat++;
    end
    if (lat >= 50) check("out_valid_timeout", VW'(out_valid), VW'(1));
  endtask

  task automatic drain;
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      tick;
      n++;
    end
    if (n >= 50) check("drain_timeout", VW'(exp_q.size()), VW'(0));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, lat;
    bit seen;
    logic [VW-1:0] held;

    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_sel = '0; wr_data = '0;
    in_valid = 1'b0; x1_in = '0; x2_in = '0; out_ready = 1'b0; use_step = 1'b1;
    for (int i = 0; i < N; i++) begin mw1[i] = '0; mw2[i] = '0; mwb[i] = '0; end
    tick;
    tick;
    check("rst_in_ready", VW'(in_ready), VW'(1));
    check("rst_wr_ready", VW'(wr_ready), VW'(1));
    check("rst_out_valid", VW'(out_valid), VW'(0));
    check("rst_out_vec", out_vec, '0);
    rst_n = 1'b1;
    repeat (10) tick;
    check("idle_out_vec", out_vec, '0);
    check("idle_out_valid", VW'(out_valid), VW'(0));
    check("idle_in_ready", VW'(in_ready), VW'(1));

    // Step-activation layer: biases 0, -1, -2, -3.
    for (int i = 0; i < N; i++) begin
      write_w(i, 0, ONE, w);
      write_w(i, 1, ONE, w);
      write_w(i, 2, fixed_t'(-i * 65536), w);
    end
    send_input(ONE, ONE, w);
    wait_valid(lat);
    check("step_latency", VW'(lat), VW'(LAT));
    check("step_vec", out_vec, {fixed_t'(0), ONE, ONE, ONE});

    // Back-pressure in DONE with a pending input.
    held     = out_vec;
    in_valid = 1'b1;
    x1_in    = HALF;
    x2_in    = HALF;
    repeat (5) begin
      tick;
      check("hold_vec", out_vec, held);
      check("hold_in_ready", VW'(in_ready), VW'(0));
      check("hold_out_valid", VW'(out_valid), VW'(1));
    end
    out_ready = 1'b1;
    tick;
    check("release_in_ready", VW'(in_ready), VW'(1));
    check("release_out_valid", VW'(out_valid), VW'(0));
    send_input(HALF, HALF, w);
    check("held_input_wait", VW'(w), VW'(0));
    wait_valid(lat);
    check("half_latency", VW'(lat), VW'(LAT));
    check("half_vec", out_vec, {fixed_t'(0), fixed_t'(0), ONE, ONE});

    // Write held during EVAL: in-flight vector keeps old weights.
    send_input(ONE, ONE, w);
    check("eval_wr_ready", VW'(wr_ready), VW'(0));
    write_w(0, 2, fixed_t'(-4 * 65536), w);
    check("eval_write_wait", VW'(w), VW'(LAT + 1));
    // Write and input accepted in the same IDLE cycle: the new weight applies.
    wr_en = 1'b1; wr_addr = 2'd1; wr_sel = SEL_WB; wr_data = fixed_t'(-5 * 65536);
    in_valid = 1'b1; x1_in = ONE; x2_in = ONE;
    check("same_cycle_ready", VW'({in_ready, wr_ready}), VW'(2'b11));
    mwb[1] = fixed_t'(-5 * 65536);
    exp_q.push_back(model_vec(ONE, ONE));
    tick;
    wr_en = 1'b0;
    in_valid = 1'b0;
    wait_valid(lat);
    check("same_cycle_latency", VW'(lat), VW'(LAT));
    check("same_cycle_vec", out_vec, {fixed_t'(0), ONE, fixed_t'(0), fixed_t'(0)});
    drain();

    // Reset at EVAL idx==2 discards the partial vector and the bank.
    send_input(ONE, ONE, w);
    tick;
    tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    exp_q.delete();
    for (int i = 0; i < N; i++) begin mw1[i] = '0; mw2[i] = '0; mwb[i] = '0; end
    check("abort_out_valid", VW'(out_valid), VW'(0));
    check("abort_out_vec", out_vec, '0);
    check("abort_in_ready", VW'(in_ready), VW'(1));
    seen = 1'b0;
    repeat (10) begin
      tick;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    check("no_stale", VW'(seen), VW'(0));

    // Random linear-neuron layer, 100 back-to-back vectors.
    use_step = 1'b0;
    for (int i = 0; i < N; i++) begin
      for (int s = 0; s < 4; s++) write_w(i, s, fixed_t'($urandom), w);
    end
    for (int k = 0; k < 100; k++) begin
      send_input(fixed_t'($urandom), fixed_t'($urandom), w);
      wait_valid(lat);
      check("rand_latency", VW'(lat), VW'(LAT));
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/perceptron_layer_scheduler.md
# perceptron_layer_scheduler

Time-multiplexes one shared combinational `neuron` datapath across `NUM_NEURONS` weight sets, evaluating a full perceptron layer for each accepted input pair. The block sits between the input source and the next layer. It holds per-neuron weights in a writable bank, drives the shared neuron one index per cycle, and collects the activations into an output vector. The input and output sides use valid/ready handshakes.

## Interface
- `NUM_NEURONS`, 4: neurons in the layer, ≥1
- `SIGN`, 1: sign bits of fixed-point word
- `Q_M`, 15: integer bits
- `Q_N`, 16: fraction bits; word width `W = SIGN+Q_M+Q_N`
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: synchronous, active-low reset
- `wr_en` in 1: weight write strobe
- `wr_addr` in `$clog2(NUM_NEURONS)` (min 1): neuron index
- `wr_sel` in 2: 0=w1, 1=w2, 2=wb, 3=ignored
- `wr_data` in W: weight value
- `wr_ready` out 1: write accepted when high
- `in_valid` in 1: input pair valid
- `in_ready` out 1: scheduler can accept input
- `x1_in`, `x2_in` in W: input operands
- `out_valid` out 1: result vector valid
- `out_ready` in 1: consumer accepts vector
- `out_vec` out `NUM_NEURONS*W`: activation of neuron i at bits `[i*W +: W]`
- `n_x1`, `n_x2`, `n_w1`, `n_w2`, `n_wb` out W each: drive the shared neuron
- `n_out` in W: shared neuron activation

## Operation
- FSM states: IDLE, EVAL, DONE.
- IDLE:
  - `in_ready`=1 and `wr_ready`=1.
  - On `in_valid`: latch `x1_in`/`x2_in`, set `idx`=0, go to EVAL.
- EVAL:
  - `n_x1`/`n_x2` carry the latched inputs.
  - `n_w*` carry `bank[idx]` through a combinational read.
  - Each cycle, `n_out` is stored into `out_vec[idx]`.
  - When `idx==NUM_NEURONS-1`, go to DONE; otherwise `idx++`.
- DONE:
  - `out_valid`=1.
  - On `out_ready`, go to IDLE.
  - `out_vec` holds its value until the next EVAL overwrites it.
- Weight writes are taken only when `wr_en && wr_ready`. In EVAL and DONE, `wr_ready`=0 and writes are dropped; the writer must hold `wr_en` until it sees `wr_ready`.
- A `wr_addr` ≥ `NUM_NEURONS` or `wr_sel`==3 is acknowledged and has no effect.
- `in_valid` outside IDLE is not consumed, because `in_ready`=0.
- A write and an input acceptance in the same IDLE cycle are both taken. The new weight is used, because EVAL reads the bank from the next cycle onward.
- Outside EVAL, the `n_*` outputs carry the latched inputs with `bank[0]`. They are don't-care but stable.
- No saturation is applied here; the arithmetic is whatever the shared neuron does.

## Timing
- Reset (`rst_n`=0 at an edge) sets:
  - state IDLE, `idx`=0
  - `out_valid`=0, `in_ready`=1, `wr_ready`=1
  - `out_vec`=0, latched inputs 0, all bank weights 0
- Reset mid-EVAL or mid-DONE aborts the operation; the partial vector is discarded (cleared).
- Latency: with input accepted at edge T, `out_valid` rises after edge T+`NUM_NEURONS`.
- Throughput: one vector per `NUM_NEURONS`+2 cycles when `out_ready` is held at 1.
- `out_valid` and `out_vec` are registered. `in_ready` and `wr_ready` are decoded from the registered state.

## Configuration
- `PERCEPTRON_SCHED_PIPE_EN` defined:
  - `n_out` is registered before capture, so `out_vec[idx-1]` is written in each EVAL cycle.
  - EVAL lasts `NUM_NEURONS`+1 cycles, with a final drain cycle.
  - Latency is `NUM_NEURONS`+1.
  - The bank address still advances one per cycle.
- Not defined: direct same-cycle capture as described in Operation.

## Structure
- Shared package `perceptron_pkg`:
  - `localparam` W derivation
  - `typedef logic [W-1:0] fixed_t`
  - `typedef enum {IDLE, EVAL, DONE} sched_state_t`
  - `wr_sel` encodings `SEL_W1`/`SEL_W2`/`SEL_WB`
- Sub-module `weight_bank`: `NUM_NEURONS`×3 register file with a synchronous write and a combinational read by `idx`.
- The scheduler instantiates `weight_bank`. The `neuron` stays outside, connected at the parent level.

## Test plan
- Reset then idle:
  - all outputs at their reset values
  - `in_ready`=1
  - `out_vec`=0 after 10 cycles
- Program 4 neurons with w1=w2=0x0001_0000 and wb = 0, -0x0001_0000, -0x0002_0000, -0x0003_0000, using a reference neuron model with step activation. Send x1=x2=0x0001_0000:
  - `out_valid` exactly 4 cycles after acceptance
  - vector = [1.0, 1.0, 1.0, 0]
- Hold `out_ready`=0 for 5 cycles in DONE:
  - `out_vec` stable
  - `in_ready`=0; an asserted `in_valid` is not consumed
  - after `out_ready`, the next input is taken 1 cycle later
- Write attempts during EVAL with `wr_en` held:
  - accepted only after return to IDLE
  - the in-flight vector uses the old weights
- Assert `rst_n`=0 at EVAL idx=2:
  - next cycle is IDLE with `out_vec`=0 and `out_valid`=0
  - no stale result ever appears
- Back-to-back 100 random vectors with `out_ready`=1, run with and without `PERCEPTRON_SCHED_PIPE_EN`:
  - scoreboard matches the model
  - latency is 4 or 5 respectively
